multi_digit_counter_display: RTL and testbench

//  Parametrised N-digit up/down counter driving DE2-115 seven-segment displays.

---
 rtl/counter_disp_pkg.sv | 41 ++++
 rtl/multi_digit_counter_display_if.sv | 23 ++
 rtl/hex7seg.sv | 28 ++
 rtl/multi_digit_counter_display.sv | 102 ++++++++++
 tb/tb_multi_digit_counter_display.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_disp_pkg.sv
// Shared constants and the single-digit up/down step used by the counter chain.
package counter_disp_pkg;

  localparam logic [6:0] SEG_BLANK     = 7'b1111111;
  localparam logic [6:0] SEG_ZERO      = 7'b0000001;
  localparam logic [3:0] DIGIT_MAX_HEX = 4'hF;
  localparam logic [3:0] DIGIT_MAX_BCD = 4'h9;

  typedef struct packed {
    logic       carry;
    logic [3:0] val;
  } digit_step_t;

  // Out-of-range BCD digits wrap to 0 with carry going up, and clamp to 9 without borrow going down.
  function automatic digit_step_t digit_step(input logic [3:0] val, input logic up, input logic bcd);
    digit_step_t r;
    logic [3:0]  mx;
    mx      = bcd ? DIGIT_MAX_BCD : DIGIT_MAX_HEX;
    r.carry = 1'b0;
    r.val   = val;
    if (up) begin
      if (val >= mx) begin
        r.val   = '0;
        r.carry = 1'b1;
      end else begin
        r.val = val + 4'd1;
      end
    end else begin
      if (val == '0) begin
        r.val   = mx;
        r.carry = 1'b1;
      end else if (val > mx) begin
        r.val = mx;
      end else begin
        r.val = val - 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/multi_digit_counter_display_if.sv
// Control/data bundle between the board top and the counter/display block.
interface multi_digit_counter_display_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                    en;
  logic                    up;
  logic                    bcd_mode;
  logic                    load;
  logic [NUM_DIGITS*4-1:0] load_val;
  logic [NUM_DIGITS*4-1:0] count;
  logic                    tc;
  logic [NUM_DIGITS*7-1:0] HEX;

  modport master (
    output en, up, bcd_mode, load, load_val,
    input  count, tc, HEX
  );

  modport slave (
    input  en, up, bcd_mode, load, load_val,
    output count, tc, HEX
  );
endinterface

// File: rtl/hex7seg.sv
// Nibble to active-low seven-segment glyph, bit 6 = segment a .. bit 0 = segment g.
module hex7seg (
  input  logic [3:0] i_num,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = 7'b1111111;
    case (i_num)
      4'h0: o_seg = 7'b0000001;
      4'h1: o_seg = 7'b1001111;
      4'h2: o_seg = 7'b0010010;
      4'h3: o_seg = 7'b0000110;
      4'h4: o_seg = 7'b1001100;
      4'h5: o_seg = 7'b0100100;
      4'h6: o_seg = 7'b0100000;
      4'h7: o_seg = 7'b0001111;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0000100;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b1100000;
      4'hC: o_seg = 7'b0110001;
      4'hD: o_seg = 7'b1000010;
      4'hE: o_seg = 7'b0110000;
      4'hF: o_seg = 7'b0111000;
      default: o_seg = 7'b1111111;
    endcase
  end
endmodule

// File: rtl/multi_digit_counter_display.sv
// N-digit hex/BCD up/down counter with prescaler, wrap pulse and registered seven-segment outputs.
module multi_digit_counter_display
  import counter_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned TICK_DIV   = 10000000,
  parameter bit          BLANK_LZ   = 1'b0
) (
  input logic                          CLOCK_50,
  input logic                          RESETN,
  multi_digit_counter_display_if.slave bus
);

  localparam int unsigned CW = NUM_DIGITS * 4;
  localparam int unsigned HW = NUM_DIGITS * 7;
  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  function automatic logic [HW-1:0] reset_hex();
    logic [HW-1:0] h;
    for (int unsigned k = 0; k < NUM_DIGITS; k++)
      h[7*k +: 7] = (BLANK_LZ && k != 0) ? SEG_BLANK : SEG_ZERO;
    return h;
  endfunction

  localparam logic [HW-1:0] RST_HEX = reset_hex();

  logic [TW-1:0]       r_tick_cnt;
  logic [CW-1:0]       r_count;
  logic                r_tc;
  logic [HW-1:0]       r_hex;
  logic                w_tick;
  logic [CW-1:0]       w_next;
  logic [NUM_DIGITS:0] w_carry;
  digit_step_t         w_step;
  logic [HW-1:0]       w_seg;
  logic [HW-1:0]       w_disp;
  logic                w_zero_run;

  assign w_tick = bus.en && (r_tick_cnt == TICK_LAST);

  // Ripple chain: a digit only steps when every lower digit carried/borrowed.
  always_comb begin
    w_next     = r_count;
    w_carry    = '0;
    w_carry[0] = 1'b1;
    w_step     = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      w_step = digit_step(r_count[4*k +: 4], bus.up, bus.bcd_mode);
      if (w_carry[k])
        w_next[4*k +: 4] = w_step.val;
      w_carry[k+1] = w_carry[k] & w_step.carry;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    hex7seg u_hex7seg (
      .i_num (r_count[4*g +: 4]),
      .o_seg (w_seg[7*g +: 7])
    );
  end

  // Scan from the top digit down; blanking stops at the first non-zero digit.
  always_comb begin
    w_disp     = w_seg;
    w_zero_run = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      w_zero_run = w_zero_run && (r_count[4*(NUM_DIGITS-1-i) +: 4] == 4'h0);
      if (BLANK_LZ && (i != NUM_DIGITS - 1) && w_zero_run)
        w_disp[7*(NUM_DIGITS-1-i) +: 7] = SEG_BLANK;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESETN) begin
      r_tick_cnt <= '0;
      r_count    <= '0;
      r_tc       <= 1'b0;
      r_hex      <= RST_HEX;
    end else begin
      r_hex <= w_disp;
      if (bus.load) begin
        r_count    <= bus.load_val;
        r_tick_cnt <= '0;
        r_tc       <= 1'b0;
      end else if (w_tick) begin
        r_count    <= w_next;
        r_tick_cnt <= '0;
        r_tc       <= w_carry[NUM_DIGITS];
      end else begin
        r_tc <= 1'b0;
        if (bus.en)
          r_tick_cnt <= r_tick_cnt + TW'(1);
      end
    end
  end

  assign bus.count = r_count;
  assign bus.tc    = r_tc;
  assign bus.HEX   = r_hex;

endmodule

// File: tb/tb_multi_digit_counter_display.sv
// Bench for multi_digit_counter_display: two instances (plain and leading-zero blanking) share stimulus.
module tb_multi_digit_counter_display;

  localparam int unsigned ND = 4;
  localparam int unsigned TD = 4;
  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] SB = 7'b1111111;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en, up, bcd, load;
  logic [15:0] load_val;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] m_count;
  logic [15:0] prev_count;
  logic        mon_en = 1'b0;

  always #5 clk = ~clk;

  multi_digit_counter_display_if #(.NUM_DIGITS(ND)) bus0 ();
  multi_digit_counter_display_if #(.NUM_DIGITS(ND)) bus1 ();

  assign bus0.en = en;  assign bus0.up = up;  assign bus0.bcd_mode = bcd;
  assign bus0.load = load;  assign bus0.load_val = load_val;
  assign bus1.en = en;  assign bus1.up = up;  assign bus1.bcd_mode = bcd;
  assign bus1.load = load;  assign bus1.load_val = load_val;

  multi_digit_counter_display #(.NUM_DIGITS(ND), .TICK_DIV(TD), .BLANK_LZ(1'b0)) dut0 (
    .CLOCK_50 (clk),
    .RESETN   (rstn),
    .bus      (bus0)
  );

  multi_digit_counter_display #(.NUM_DIGITS(ND), .TICK_DIV(TD), .BLANK_LZ(1'b1)) dut1 (
    .CLOCK_50 (clk),
    .RESETN   (rstn),
    .bus      (bus1)
  );

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  function automatic logic [27:0] exp_hex(input logic [15:0] v, input logic blank);
    logic [27:0] h;
    logic        z;
    z = 1'b1;
    for (int k = 3; k >= 0; k--) begin
      z = z && (v[4*k +: 4] == 4'h0);
      h[7*k +: 7] = (blank && k != 0 && z) ? SB : seg(v[4*k +: 4]);
    end
    return h;
  endfunction

  // Returns {tc, next}. Hex is plain modular arithmetic; BCD walks digits.
  function automatic logic [16:0] model_step(input logic [15:0] v, input logic u, input logic b);
    logic [15:0] r;
    logic        c;
    logic [3:0]  d;
    if (!b) begin
      r = u ? v + 16'd1 : v - 16'd1;
      c = u ? (v == 16'hFFFF) : (v == 16'h0000);
    end else begin
      r = v;
      c = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (c) begin
          d = v[4*k +: 4];
          if (u) begin
            if (d >= 4'd9) r[4*k +: 4] = 4'd0;
            else begin r[4*k +: 4] = d + 4'd1; c = 1'b0; end
          end else begin
            if (d == 4'd0) r[4*k +: 4] = 4'd9;
            else if (d > 4'd9) begin r[4*k +: 4] = 4'd9; c = 1'b0; end
            else begin r[4*k +: 4] = d - 4'd1; c = 1'b0; end
          end
        end
      end
    end
    return {c, r};
  endfunction

  // Scoreboard consumer: every change of count must match the next queued value.
  always @(negedge clk) begin
    if (mon_en && bus0.count !== prev_count) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL count_seq: count changed to %h, no change expected", bus0.count);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (bus0.count !== e) begin
          errors++;
          $display("FAIL count_seq: count %h, expected %h", bus0.count, e);
        end
      end
    end
    prev_count = bus0.count;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic do_load(input logic [15:0] v);
    load = 1'b1;
    load_val = v;
    if (v != m_count) exp_q.push_back(v);
    @(negedge clk);
    load = 1'b0;
    m_count = v;
    checks++;
    if (bus0.count !== v || bus0.tc !== 1'b0) begin
      errors++;
      $display("FAIL load: count %h tc %b, expected %h tc 0", bus0.count, bus0.tc, v);
    end
  endtask

  // Assumes the prescaler is at 0 on entry (after reset, load or a step).
  task automatic do_step(input logic dir, input logic b);
    logic [16:0] r;
    up  = dir;
    bcd = b;
    r = model_step(m_count, dir, b);
    exp_q.push_back(r[15:0]);
    for (int i = 1; i <= TD; i++) begin
      @(negedge clk);
      if (i == 1) begin
        checks += 2;
        if (bus0.HEX !== exp_hex(m_count, 1'b0)) begin
          errors++;
          $display("FAIL hex_plain: HEX %h, expected %h", bus0.HEX, exp_hex(m_count, 1'b0));
        end
        if (bus1.HEX !== exp_hex(m_count, 1'b1)) begin
          errors++;
          $display("FAIL hex_blank: HEX %h, expected %h", bus1.HEX, exp_hex(m_count, 1'b1));
        end
      end
      checks++;
      if (i < TD) begin
        if (bus0.count !== m_count || bus0.tc !== 1'b0) begin
          errors++;
          $display("FAIL step_early: count %h tc %b, expected %h tc 0", bus0.count, bus0.tc, m_count);
        end
      end else if (bus0.count !== r[15:0] || bus0.tc !== r[16]) begin
        errors++;
        $display("FAIL step: count %h tc %b, expected %h tc %b", bus0.count, bus0.tc, r[15:0], r[16]);
      end
    end
    m_count = r[15:0];
  endtask

  task automatic test_reset;
    rstn = 1'b0; load = 1'b1; load_val = 16'h1234; en = 1'b1; up = 1'b1; bcd = 1'b0;
    repeat (3) @(negedge clk);
    checks += 3;
    if (bus0.count !== 16'h0000 || bus0.tc !== 1'b0) begin
      errors++;
      $display("FAIL reset_count: count %h tc %b, expected 0000 tc 0", bus0.count, bus0.tc);
    end
    if (bus0.HEX !== {S0, S0, S0, S0}) begin
      errors++;
      $display("FAIL reset_hex: HEX %h, expected %h", bus0.HEX, {S0, S0, S0, S0});
    end
    if (bus1.HEX !== {SB, SB, SB, S0}) begin
      errors++;
      $display("FAIL reset_hex_blank: HEX %h, expected %h", bus1.HEX, {SB, SB, SB, S0});
    end
    rstn = 1'b1; load = 1'b0;
    m_count = 16'h0000;
    mon_en = 1'b1;
  endtask

  task automatic test_count_up;
    for (int n = 0; n < 16; n++) do_step(1'b1, 1'b0);
    @(negedge clk);
    checks += 2;
    if (bus0.HEX !== {S0, S0, S1, S0}) begin
      errors++;
      $display("FAIL hex_0010: HEX %h, expected %h", bus0.HEX, {S0, S0, S1, S0});
    end
    if (bus1.HEX !== {SB, SB, S1, S0}) begin
      errors++;
      $display("FAIL hex_0010_blank: HEX %h, expected %h", bus1.HEX, {SB, SB, S1, S0});
    end
  endtask

  task automatic test_wrap_hex;
    do_load(16'hFFFE);
    do_step(1'b1, 1'b0);
    do_step(1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (bus0.tc !== 1'b0) begin
      errors++;
      $display("FAIL tc_width: tc %b one cycle after wrap, expected 0", bus0.tc);
    end
  endtask

  task automatic test_bcd;
    do_load(16'h0099);
    do_step(1'b1, 1'b1);
    do_load(16'h0000);
    do_step(1'b0, 1'b1);
  endtask

  task automatic test_bcd_invalid;
    do_load(16'h00A0);
    for (int n = 0; n < 10; n++) do_step(1'b1, 1'b1);
  endtask

  task automatic test_freeze;
    do_load(16'h0005);
    up = 1'b1; bcd = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      checks++;
      if (bus0.count !== 16'h0005) begin
        errors++;
        $display("FAIL freeze: count %h, expected 0005", bus0.count);
      end
    end
    en = 1'b1;
    exp_q.push_back(16'h0006);
    @(negedge clk);
    checks++;
    if (bus0.count !== 16'h0005) begin
      errors++;
      $display("FAIL resume_early: count %h, expected 0005", bus0.count);
    end
    @(negedge clk);
    checks++;
    if (bus0.count !== 16'h0006) begin
      errors++;
      $display("FAIL resume: count %h, expected 0006", bus0.count);
    end
    m_count = 16'h0006;
  endtask

  task automatic test_blank;
    logic [15:0] vals[3];
    logic [27:0] want0[3];
    logic [27:0] want1[3];
    vals  = '{16'h0042, 16'h0102, 16'h0000};
    want0 = '{{S0, S0, S4, S2}, {S0, S1, S0, S2}, {S0, S0, S0, S0}};
    want1 = '{{SB, SB, S4, S2}, {SB, S1, S0, S2}, {SB, SB, SB, S0}};
    for (int n = 0; n < 3; n++) begin
      do_load(vals[n]);
      @(negedge clk);
      checks += 2;
      if (bus0.HEX !== want0[n]) begin
        errors++;
        $display("FAIL blank_plain %h: HEX %h, expected %h", vals[n], bus0.HEX, want0[n]);
      end
      if (bus1.HEX !== want1[n]) begin
        errors++;
        $display("FAIL blank_lz %h: HEX %h, expected %h", vals[n], bus1.HEX, want1[n]);
      end
    end
  endtask

  task automatic test_back_to_back;
    do_load(16'h1234);
    do_load(16'h0010);
    do_step(1'b0, 1'b1);
    do_load(16'h00B0);
    do_step(1'b0, 1'b1);
    do_load(16'h0100);
    do_step(1'b0, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_count_up;
    test_wrap_hex;
    test_bcd;
    test_bcd_invalid;
    test_freeze;
    test_blank;
    test_back_to_back;
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected values never seen, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
